// File: rtl/gray_pair_tracker_pkg.sv
// gray_pair_tracker_pkg: shared states, step classes and defaults for the Gray pair tracker
package gray_pair_tracker_pkg;
  typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;
  typedef enum logic [1:0] {HOLD, UP, DOWN, ILLEGAL} step_t;
  localparam int MAX_ERR_DEF = 3;
  localparam int POS_W_DEF = 16;
endpackage

// File: rtl/gray_pair_tracker_gray4_to_bin.sv
// gray4_to_bin: combinational 4-bit reflected Gray to binary converter
module gray4_to_bin (
  input  logic [3:0] g,
  output logic [3:0] b
);
  assign b = {g[3], ^g[3:2], ^g[3:1], ^g[3:0]};
endmodule

// File: rtl/gray_pair_tracker.sv
// gray_pair_tracker: decodes a two-nibble Gray word, classifies steps, tracks position and integrity
module gray_pair_tracker
  import gray_pair_tracker_pkg::*;
#(
  parameter int MAX_ERR = MAX_ERR_DEF,
  parameter int POS_W = POS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              gray_in,
  input  logic                    vld,
  input  logic                    clr,
  output logic [7:0]              bin,
  output logic                    up,
  output logic                    dn,
  output logic                    err,
  output logic                    fault,
  output logic signed [POS_W-1:0] pos
);
  state_t state, state_d;
  step_t cls;
  logic [3:0] hi, lo, err_cnt, cnt_d, cnt_inc;
  logic [7:0] v, d, bin_d;
  logic signed [POS_W-1:0] pos_d;
  logic up_d, dn_d, err_d;
  gray4_to_bin u_hi (.g(gray_in[7:4]), .b(hi));
  gray4_to_bin u_lo (.g(gray_in[3:0]), .b(lo));
  assign v = {hi, lo};
  assign d = v - bin;
  assign cls = d == 8'h00 ? HOLD : d == 8'h01 ? UP : d == 8'hff ? DOWN : ILLEGAL;
  // error run length saturates so a long burst cannot wrap back below the limit
  assign cnt_inc = err_cnt == 4'hf ? err_cnt : err_cnt + 4'd1;
  assign fault = state == FAULT;
  always_comb begin
    state_d = state;
    bin_d = bin;
    pos_d = pos;
    cnt_d = err_cnt;
    err_d = err;
    up_d = 1'b0;
    dn_d = 1'b0;
    if (clr) begin
      state_d = ACQUIRE;
      bin_d = '0;
      pos_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (vld) begin
      case (state)
        ACQUIRE: begin
          bin_d = v;
          state_d = TRACK;
        end
        TRACK: begin
          bin_d = v;
          cnt_d = cls == ILLEGAL ? cnt_inc : 4'd0;
          up_d = cls == UP;
          dn_d = cls == DOWN;
          pos_d = cls == UP ? pos + POS_W'(1) : cls == DOWN ? pos - POS_W'(1) : pos;
          err_d = err | (cls == ILLEGAL);
          state_d = cls == ILLEGAL && cnt_inc >= 4'(MAX_ERR) ? FAULT : TRACK;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ACQUIRE;
      bin <= '0;
      pos <= '0;
      err_cnt <= '0;
      err <= 1'b0;
      up <= 1'b0;
      dn <= 1'b0;
    end else begin
      state <= state_d;
      bin <= bin_d;
      pos <= pos_d;
      err_cnt <= cnt_d;
      err <= err_d;
      up <= up_d;
      dn <= dn_d;
    end
endmodule

// File: doc/gray_pair_tracker.md
# gray_pair_tracker

Receive-side companion to the two-digit Gray up/down counter. It samples the 8-bit two-nibble Gray word on a strobe and decodes each nibble to binary. It classifies every sample against the previous one as hold, up-step or down-step, and flags illegal jumps. It maintains a signed position accumulator so downstream logic (display, monitor) sees decoded value, motion direction and integrity status without re-implementing Gray decoding.

## Interface
Parameters:
- MAX_ERR, 3: consecutive illegal samples that force the FAULT state (1..15).
- POS_W, 16: width of the signed position accumulator.

Ports:
- clk  in  1  sampling clock, rising edge; the counter updates on falling edge, so `gray_in` is stable at every rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- gray_in  in  8  [7:4] high-digit Gray nibble, [3:0] low-digit Gray nibble (each standard reflected 4-bit Gray).
- vld  in  1  sample strobe; `gray_in` is evaluated only when high.
- clr  in  1  synchronous clear: returns to ACQUIRE, zeroes `pos`, `err_cnt` and `err`.
- bin  out  8  decoded binary value of the last accepted sample, {hi, lo}.
- up  out  1  one-cycle pulse when a +1 step is accepted.
- dn  out  1  one-cycle pulse when a −1 step is accepted.
- err  out  1  sticky; set on any illegal sample, cleared only by `clr` or reset.
- fault  out  1  high while in FAULT.
- pos  out  POS_W  signed net step count since acquisition; wraps two's-complement.

## Operation
- Decode: each nibble goes through binary b3=g3, bi=g(i)^b(i+1). The combined value is V={hi_bin, lo_bin}. Every 8-bit input is a decodable word.
- Step classification, with d = (V − bin) mod 256:
  - d=0: hold.
  - d=1: up.
  - d=255: down.
  - Otherwise: illegal.
- Wrap-around is legal: 0xFF→0x00 is up and 0x00→0xFF is down. The low-digit carry changes two input bits (e.g. 8'h08→8'h10) and is legal.
- States:
  - ACQUIRE: the first `vld` loads `bin`=V with no pulse and no `pos` change, then goes to TRACK.
  - TRACK: hold leaves everything unchanged and resets `err_cnt`. Up/down updates `bin`, pulses `up`/`dn`, adds ±1 to `pos` and resets `err_cnt`. Illegal sets `err`, increments `err_cnt` and resynchronises `bin`=V with no pulse and no `pos` change. When `err_cnt` reaches MAX_ERR the block goes to FAULT.
  - FAULT: `fault`=1 and samples are ignored (`bin` frozen, no pulses). Only `clr` or reset exits.
- Priority within a cycle: reset > clr > vld. If `clr` and `vld` are both high, the clear wins and the sample is discarded. The next `vld` is an ACQUIRE load.
- `up` and `dn` are never high together. Pulses occur only in TRACK.

## Timing
- All outputs are registered. Results appear the cycle after the rising edge where `vld`=1, so latency is 1 clock.
- `up`/`dn` are high for exactly one cycle per accepted step. Back-to-back `vld` gives back-to-back pulses.
- `vld` low: all state holds and pulses are 0.
- Reset values: state ACQUIRE, `bin`=8'h00, `up`=`dn`=0, `err`=0, `fault`=0, `pos`=0, internal `err_cnt`=0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Structure
- Shared package holds:
  - state enum {ACQUIRE, TRACK, FAULT}.
  - step-class enum {HOLD, UP, DOWN, ILLEGAL}.
  - default constants for MAX_ERR and POS_W.
- Sub-module `gray4_to_bin` is a combinational 4-bit Gray-to-binary converter, instantiated twice (hi, lo).
- Top level contains: modular subtract/classify, 3-state FSM, `err_cnt` (4 bits), `pos` accumulator, output registers.

## Test plan
- Reset, then `vld` with 8'h00 → `bin`=8'h00, no pulse, state TRACK. Next `vld` with 8'h01 → `bin`=8'h01, `up`=1 for one cycle, `pos`=1.
- Low-digit carry up: 8'h08 (V=0x0F) then 8'h10 → `bin`=8'h10, `up` pulse. The reverse order gives a `dn` pulse, and `pos` returns to its prior value.
- Full wrap: 8'h88 (V=0xFF) then 8'h00 → `up` pulse, `bin`=8'h00. Then 8'h88 → `dn` pulse, `bin`=8'hFF.
- Illegal jump: 8'h00 then 8'h02 (V=0x03) → `err`=1, no pulse, `bin`=8'h03, `pos` unchanged. A following 8'h06 (V=0x04) → `up` pulse, `err` still 1.
- Three consecutive illegal samples (8'h00, 8'h07, 8'h00, 8'h07) with MAX_ERR=3 → `fault`=1, later legal samples ignored. `clr` → `fault`=0, `err`=0, `pos`=0, state ACQUIRE.
- `clr` and `vld` in the same cycle → sample discarded, all outputs at clear values. Async reset pulse between two `vld` strobes → all outputs return to reset values without a clock edge.
